// File: rtl/tl_mem_burst_slv.sv
// TileLink-UH memory slave: multi-beat Get/Put bursts, byte-masked writes, fixed response latency, range denial.
// Optional macro TL_MEM_BACKPRESSURE_EN adds LFSR-driven stalls on a_ready and on the first d_valid of a response.
module tl_mem_burst_slv #(
    parameter int unsigned   DW      = 128,
    parameter int unsigned   AW      = 32,
    parameter int unsigned   DEPTH   = 16384,
    parameter logic [AW-1:0] BASE    = AW'(32'h8000_0000),
    parameter int unsigned   LATENCY = 2,
    parameter int unsigned   SW      = 3
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [7:0]        a_size,
    input  logic [SW-1:0]     a_source,
    input  logic [AW-1:0]     a_address,
    input  logic [DW/8-1:0]   a_mask,
    input  logic [DW-1:0]     a_data,
    input  logic              a_corrupt,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [7:0]        d_size,
    output logic [SW-1:0]     d_source,
    output logic [SW-1:0]     d_sink,
    output logic              d_denied,
    output logic [DW-1:0]     d_data,
    output logic              d_corrupt,
    output logic [1:0]        o_dbg_state
);

    localparam int unsigned BYTES  = DW / 8;
    localparam int unsigned OFFW   = $clog2(BYTES);
    localparam int unsigned IW     = $clog2(DEPTH);
    localparam int unsigned CW     = IW + 1;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUT  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Valid/ready: a beat transfers on a rising CLK edge where valid and ready are both high;
    // d_valid never depends combinationally on d_ready, and d_* hold steady while d_valid waits.

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_alive;
    logic              r_get;
    logic              r_deny;
    logic [7:0]        r_size;
    logic [SW-1:0]     r_source;
    logic [IW-1:0]     r_word;
    logic [CW-1:0]     r_nbeats;
    logic [CW-1:0]     r_beat;
    logic [3:0]        r_lat;
    logic [DW-1:0]     r_rdata;
    logic [DW-1:0]     ram [DEPTH];

    logic [AW-1:0]     w_amask;
    logic              w_size_big;
    logic [CW-1:0]     w_nbeats;
    logic [AW-1:0]     w_offset;
    logic [AW-1:0]     w_word_full;
    logic [AW:0]       w_last;
    logic              w_deny;
    logic [IW-1:0]     w_word;
    logic              w_is_get;
    logic              w_a_hs;
    logic              w_d_hs;
    logic              w_last_put;
    logic              w_last_resp;
    logic              w_we;
    logic [IW-1:0]     w_waddr;
    logic [IW-1:0]     w_rd_addr;
    logic              w_in_resp;
    logic              w_a_stall;
    logic              w_d_stall;
    logic              w_unused;

    assign w_unused = ^a_param;

    // First-beat request decode; huge sizes are clamped to one beat and denied.
    always_comb begin
        w_amask = '0;
        for (int i = 0; i < AW; i++) begin
            w_amask[i] = (8'(i) < a_size);
        end
        w_size_big = (a_size > 8'(OFFW + IW));
        w_nbeats   = CW'(1);
        if ((a_size > 8'(OFFW)) && !w_size_big) begin
            w_nbeats = CW'(1) << (a_size - 8'(OFFW));
        end
    end

    assign w_offset    = a_address - BASE;
    assign w_word_full = w_offset >> OFFW;
    assign w_last      = {1'b0, w_word_full} + (AW+1)'(w_nbeats) - (AW+1)'(1);
    assign w_word      = w_word_full[IW-1:0];
    assign w_is_get    = (a_opcode == 3'd4);
    assign w_deny      = !((a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4))
                       || (a_address < BASE)
                       || (|(a_address & w_amask))
                       || w_size_big
                       || (w_last >= (AW+1)'(DEPTH));

    assign w_a_hs      = a_valid && a_ready;
    assign w_d_hs      = d_valid && d_ready;
    assign w_last_put  = (r_beat == (r_nbeats - CW'(1)));
    assign w_last_resp = !r_get || (r_beat == (r_nbeats - CW'(1)));
    assign w_in_resp   = (r_state == S_RESP);

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = r_word;
        case (r_state)
            S_IDLE: begin
                if (w_a_hs) begin
                    w_waddr     = w_word;
                    w_we        = !w_is_get && !w_deny && !a_corrupt;
                    w_state_nxt = (w_is_get || (w_nbeats == CW'(1))) ? S_WAIT : S_PUT;
                end
            end
            S_PUT: begin
                if (w_a_hs) begin
                    w_we = !r_deny && !a_corrupt;
                    if (w_last_put) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_lat == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_d_hs && w_last_resp) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= S_IDLE;
            r_alive  <= 1'b0;
            r_get    <= 1'b0;
            r_deny   <= 1'b0;
            r_size   <= '0;
            r_source <= '0;
            r_word   <= '0;
            r_nbeats <= '0;
            r_beat   <= '0;
            r_lat    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_a_hs) begin
                        r_get    <= w_is_get;
                        r_deny   <= w_deny;
                        r_size   <= a_size;
                        r_source <= a_source;
                        // Puts keep r_word pointing at the next beat to write.
                        r_word   <= w_is_get ? w_word : (w_word + IW'(1));
                        r_nbeats <= w_nbeats;
                        r_beat   <= CW'(1);
                        r_lat    <= LAT_M1;
                    end
                end
                S_PUT: begin
                    if (w_a_hs) begin
                        r_word <= r_word + IW'(1);
                        r_beat <= r_beat + CW'(1);
                        r_lat  <= LAT_M1;
                    end
                end
                S_WAIT: begin
                    if (r_lat != 4'd0) begin
                        r_lat <= r_lat - 4'd1;
                    end else begin
                        r_beat <= '0;
                    end
                end
                S_RESP: begin
                    if (w_d_hs && !w_last_resp) begin
                        r_word <= r_word + IW'(1);
                        r_beat <= r_beat + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read address runs one word ahead on a D handshake so the next beat has no bubble.
    assign w_rd_addr = (w_in_resp && w_d_hs) ? (r_word + IW'(1)) : r_word;

    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (a_mask[b]) begin
                    ram[w_waddr][b*8 +: 8] <= a_data[b*8 +: 8];
                end
            end
        end
        r_rdata <= ram[w_rd_addr];
    end

`ifdef TL_MEM_BACKPRESSURE_EN
    logic [15:0] r_lfsr;
    logic        r_dv_up;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_lfsr  <= 16'hACE1;
            r_dv_up <= 1'b0;
        end else begin
            r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_dv_up <= w_in_resp && (w_state_nxt == S_RESP) && d_valid;
        end
    end

    // Once d_valid is up it stays up until the response completes.
    assign w_a_stall = r_lfsr[0];
    assign w_d_stall = r_lfsr[0] && !r_dv_up;
`else
    assign w_a_stall = 1'b0;
    assign w_d_stall = 1'b0;
`endif

    assign a_ready     = r_alive && ((r_state == S_IDLE) || (r_state == S_PUT)) && !w_a_stall;
    assign d_valid     = w_in_resp && !w_d_stall;
    assign d_opcode    = (w_in_resp && r_get) ? 3'd1 : 3'd0;
    assign d_param     = 2'd0;
    assign d_size      = w_in_resp ? r_size : 8'd0;
    assign d_source    = w_in_resp ? r_source : '0;
    assign d_sink      = '0;
    assign d_denied    = w_in_resp && r_deny;
    assign d_corrupt   = w_in_resp && r_get && r_deny;
    assign d_data      = (w_in_resp && r_get && !r_deny) ? r_rdata : '0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tl_mem_burst_slv.sv
// Directed bench for tl_mem_burst_slv: stimulus pushes expected D beats into a queue,
// an independent monitor pops and compares on every D handshake.
module tb_tl_mem_burst_slv;

    localparam int              DW      = 128;
    localparam int              AW      = 32;
    localparam int              DEPTH   = 1024;
    localparam int              LATENCY = 2;
    localparam int              SW      = 3;
    localparam logic [AW-1:0]   BASE    = 32'h8000_0000;
    localparam int              MW      = DW / 8;
    localparam int              EW      = 3 + 2 + 8 + SW + SW + 1 + 1 + DW;
    localparam logic [DW-1:0]   D0      = 128'h0123456789ABCDEF_0123456789ABCDEF;

    logic            CLK = 1'b0;
    logic            RSTn = 1'b0;
    logic            a_valid;
    logic            a_ready;
    logic [2:0]      a_opcode;
    logic [2:0]      a_param;
    logic [7:0]      a_size;
    logic [SW-1:0]   a_source;
    logic [AW-1:0]   a_address;
    logic [MW-1:0]   a_mask;
    logic [DW-1:0]   a_data;
    logic            a_corrupt;
    logic            d_valid;
    logic            d_ready;
    logic [2:0]      d_opcode;
    logic [1:0]      d_param;
    logic [7:0]      d_size;
    logic [SW-1:0]   d_source;
    logic [SW-1:0]   d_sink;
    logic            d_denied;
    logic [DW-1:0]   d_data;
    logic            d_corrupt;
    logic [1:0]      o_dbg_state;

    int              n_checks = 0;
    int              n_pass = 0;
    int              cyc = 0;
    int              last_a_cyc = 0;
    int              resp_beat = 0;
    int              stall_beat = -1;
    int              stall_left = 0;
    logic [EW-1:0]   exp_q[$];

    tl_mem_burst_slv #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LATENCY), .SW(SW)
    ) dut (
        .CLK(CLK), .RSTn(RSTn),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .d_data(d_data), .d_corrupt(d_corrupt), .o_dbg_state(o_dbg_state)
    );

    // Clock / reset / cycle counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] pre(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    function automatic logic [DW-1:0] burst(input int i);
        return {32'hDEAD_0000 + 32'(i), 32'hBEEF_0000 + 32'(i),
                32'h1234_0000 + 32'(i), 32'h5678_0000 + 32'(i)};
    endfunction

    function automatic logic [EW-1:0] pk(input logic [2:0] op, input logic [7:0] sz,
                                         input logic [SW-1:0] src, input logic den,
                                         input logic cor, input logic [DW-1:0] data);
        return {op, 2'b00, sz, src, {SW{1'b0}}, den, cor, data};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Driver: call at a negedge; returns at the negedge after the handshake edge.
    task automatic a_send(input logic [2:0] op, input logic [7:0] sz, input logic [SW-1:0] src,
                          input logic [AW-1:0] addr, input logic [MW-1:0] mask,
                          input logic [DW-1:0] data, input logic cor);
        int t;
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
        a_address = addr; a_mask = mask; a_data = data; a_corrupt = cor;
        t = 0;
        while (!a_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!a_ready) begin
            n_checks++;
            $display("FAIL a_ready_timeout: a_ready low for %0d cycles", t);
            a_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        @(negedge CLK);
        last_a_cyc = cyc;
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge CLK);
            t++;
        end
        chk("drain_queue", exp_q.size(), 0);
        @(negedge CLK);
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        logic [EW-1:0] snap;
        logic [EW-1:0] act;
        logic          hold_pend;
        logic          prev_dv;
        hold_pend = 1'b0;
        prev_dv = 1'b0;
        d_ready = 1'b1;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                hold_pend = 1'b0;
                prev_dv = 1'b0;
                d_ready = 1'b1;
            end else begin
                act = {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data};
                if (hold_pend) begin
                    chk("d_stable_valid", d_valid, 1);
                    chk("d_stable_fields", act, snap);
                end
                hold_pend = 1'b0;
`ifndef TL_MEM_BACKPRESSURE_EN
                if (d_valid && !prev_dv) chk("d_latency", cyc - last_a_cyc, LATENCY);
`endif
                prev_dv = d_valid;
                if (d_valid && resp_beat == stall_beat && stall_left > 0) begin
                    d_ready = 1'b0;
                    stall_left--;
                end else begin
                    d_ready = 1'b1;
                end
                if (d_valid && d_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL d_beat: unexpected beat %0h", act);
                    end else begin
                        chk("d_beat", act, exp_q.pop_front());
                    end
                    resp_beat++;
                end else if (d_valid) begin
                    snap = act;
                    hold_pend = 1'b1;
                end
            end
        end
    end

    // Stimulus
    initial begin : stim
        int nbad;
        a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) dut.ram[i] = pre(i);
        dut.ram[DEPTH-1] = pre(DEPTH-1);
        dut.ram[0] = D0;
        dut.ram[5] = '0;

        repeat (3) @(negedge CLK);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_d_fields", {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data}, 0);
        chk("rst_state", o_dbg_state, 0);
        RSTn = 1'b1;
        #1 chk("a_ready_before_edge", a_ready, 0);
        @(posedge CLK);
        #1 chk("a_ready_after_release", a_ready, 1);
        @(negedge CLK);

        // Single-beat Get of preloaded word 0
        exp_q.push_back(pk(3'd1, 8'd4, 3'd2, 1'b0, 1'b0, D0));
        a_send(3'd4, 8'd4, 3'd2, BASE, '1, '0, 1'b0);
        drain();
        chk("a_ready_back_idle", a_ready, 1);

        // PutPartialData low 4 bytes onto zeroed word 5, read back
        exp_q.push_back(pk(3'd0, 8'd4, 3'd3, 1'b0, 1'b0, '0));
        a_send(3'd1, 8'd4, 3'd3, BASE + 32'h50, 16'h000F, '1, 1'b0);
        drain();
        exp_q.push_back(pk(3'd1, 8'd4, 3'd3, 1'b0, 1'b0, {96'h0, 32'hFFFF_FFFF}));
        a_send(3'd4, 8'd4, 3'd3, BASE + 32'h50, '0, '0, 1'b0);
        drain();

        // 4-beat PutFullData then 4-beat Get with a 3-cycle stall on beat 2
        exp_q.push_back(pk(3'd0, 8'd6, 3'd1, 1'b0, 1'b0, '0));
        for (int b = 0; b < 4; b++) a_send(3'd0, 8'd6, 3'd1, BASE + 32'h40, '1, burst(b), 1'b0);
        drain();
        resp_beat = 0; stall_beat = 2; stall_left = 3;
        for (int b = 0; b < 4; b++) exp_q.push_back(pk(3'd1, 8'd6, 3'd4, 1'b0, 1'b0, burst(b)));
        a_send(3'd4, 8'd6, 3'd4, BASE + 32'h40, '0, '0, 1'b0);
        drain();
        chk("stall_consumed", stall_left, 0);
        stall_beat = -1;

        // Denials and range boundaries
        exp_q.push_back(pk(3'd1, 8'd4, 3'd5, 1'b1, 1'b1, '0));
        a_send(3'd4, 8'd4, 3'd5, BASE + 32'(DEPTH * 16), '0, '0, 1'b0);
        drain();
        for (int b = 0; b < 4; b++) exp_q.push_back(pk(3'd1, 8'd6, 3'd5, 1'b1, 1'b1, '0));
        a_send(3'd4, 8'd6, 3'd5, BASE + 32'(DEPTH * 16), '0, '0, 1'b0);
        drain();
        exp_q.push_back(pk(3'd1, 8'd4, 3'd6, 1'b0, 1'b0, pre(DEPTH-1)));
        a_send(3'd4, 8'd4, 3'd6, BASE + 32'((DEPTH - 1) * 16), '0, '0, 1'b0);
        drain();
        exp_q.push_back(pk(3'd0, 8'd4, 3'd0, 1'b1, 1'b0, '0));
        a_send(3'd0, 8'd4, 3'd0, BASE + 32'h108, '1, '1, 1'b0);
        drain();
        chk("misaligned_no_write", dut.ram[16], pre(16));
        exp_q.push_back(pk(3'd0, 8'd4, 3'd1, 1'b1, 1'b0, '0));
        a_send(3'd0, 8'd4, 3'd1, BASE - 32'h10, '1, '1, 1'b0);
        drain();
        chk("below_base_no_write", dut.ram[DEPTH-1], pre(DEPTH-1));
        exp_q.push_back(pk(3'd0, 8'd4, 3'd2, 1'b1, 1'b0, '0));
        a_send(3'd0, 8'd4, 3'd2, BASE + 32'(DEPTH * 16), '1, '1, 1'b0);
        drain();
        chk("out_of_range_no_write", dut.ram[0], D0);
        exp_q.push_back(pk(3'd0, 8'd4, 3'd3, 1'b0, 1'b0, '0));
        a_send(3'd0, 8'd4, 3'd3, BASE + 32'h120, '1, '1, 1'b1);
        drain();
        chk("corrupt_no_write", dut.ram[18], pre(18));
        nbad = 0;
        for (int i = 8; i < 64; i++) if (dut.ram[i] !== pre(i)) nbad++;
        chk("memory_scan", nbad, 0);

        // Reset during beat 2 of a 4-beat Put to words 32..35
        a_send(3'd0, 8'd6, 3'd7, BASE + 32'h200, '1, burst(8), 1'b0);
        a_send(3'd0, 8'd6, 3'd7, BASE + 32'h200, '1, burst(9), 1'b0);
        a_valid = 1'b1;
        a_data = burst(10);
        #2 RSTn = 1'b0;
        #1;
        chk("midrst_a_ready", a_ready, 0);
        chk("midrst_d_valid", d_valid, 0);
        chk("midrst_state", o_dbg_state, 0);
        a_valid = 1'b0;
        @(negedge CLK);
        chk("midrst_beat0", dut.ram[32], burst(8));
        chk("midrst_beat1", dut.ram[33], burst(9));
        chk("midrst_beat2", dut.ram[34], pre(34));
        chk("midrst_beat3", dut.ram[35], pre(35));
        RSTn = 1'b1;
        #1 chk("midrst_ready_before_edge", a_ready, 0);
        @(posedge CLK);
        #1 chk("midrst_ready_after_edge", a_ready, 1);
        @(negedge CLK);
        exp_q.push_back(pk(3'd1, 8'd4, 3'd0, 1'b0, 1'b0, burst(9)));
        a_send(3'd4, 8'd4, 3'd0, BASE + 32'h210, '0, '0, 1'b0);
        drain();

        repeat (5) @(negedge CLK);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
